// File: rtl/pio_ctrl_avmm.sv
// Avalon-MM output-port controller: per-channel static levels with atomic
// set/clear/toggle, a shared PWM generator and per-channel one-shot pulses.
module pio_ctrl_avmm #(
  parameter int unsigned            PIO_WIDTH = 8,
  parameter int unsigned            CNT_WIDTH = 16,
  parameter logic [PIO_WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [3:0]            avs_address_i,
  input  logic                  avs_write_i,
  input  logic [31:0]           avs_writedata_i,
  input  logic                  avs_read_i,
  output logic [31:0]           avs_readdata_o,
  output logic [PIO_WIDTH-1:0]  pio_o
);

  typedef enum logic [3:0] {
    ADDR_DATA       = 4'd0,
    ADDR_SET        = 4'd1,
    ADDR_CLR        = 4'd2,
    ADDR_TGL        = 4'd3,
    ADDR_PWM_EN     = 4'd4,
    ADDR_PWM_PERIOD = 4'd5,
    ADDR_PWM_DUTY   = 4'd6,
    ADDR_PULSE      = 4'd7,
    ADDR_PULSE_LEN  = 4'd8,
    ADDR_STATUS     = 4'd9
  } reg_addr_e;

  logic [PIO_WIDTH-1:0]                data_q, data_d;
  logic [PIO_WIDTH-1:0]                pwm_en_q, pwm_en_d;
  logic [CNT_WIDTH-1:0]                period_q, period_d;
  logic [CNT_WIDTH-1:0]                duty_q, duty_d;
  logic [CNT_WIDTH-1:0]                len_q, len_d;
  logic [CNT_WIDTH-1:0]                cnt_q, cnt_d;
  logic [PIO_WIDTH-1:0][CNT_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [PIO_WIDTH-1:0]                pio_q, pio_d;
  logic [31:0]                         rdata_q, rdata_d;

  logic [PIO_WIDTH-1:0] wd_pio;
  logic [CNT_WIDTH-1:0] wd_cnt;
  logic [PIO_WIDTH-1:0] pulse_active;
  logic                 pwm;
  logic                 unused_wd;

  assign wd_pio    = avs_writedata_i[PIO_WIDTH-1:0];
  assign wd_cnt    = avs_writedata_i[CNT_WIDTH-1:0];
  assign unused_wd = ^avs_writedata_i;

  // Register writes, PWM counter and pulse counters.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    data_d   = data_q;
    pwm_en_d = pwm_en_q;
    period_d = period_q;
    duty_d   = duty_q;
    len_d    = len_q;
    cnt_d    = (cnt_q == period_q) ? '0 : cnt_q + CNT_WIDTH'(1);

    if (avs_write_i) begin
      case (avs_address_i)
        ADDR_DATA:       data_d   = wd_pio;
        ADDR_SET:        data_d   = data_q | wd_pio;
        ADDR_CLR:        data_d   = data_q & ~wd_pio;
        ADDR_TGL:        data_d   = data_q ^ wd_pio;
        ADDR_PWM_EN:     pwm_en_d = wd_pio;
        ADDR_PWM_PERIOD: begin
          period_d = wd_cnt;
          cnt_d    = '0;
        end
        ADDR_PWM_DUTY:   duty_d   = wd_cnt;
        ADDR_PULSE_LEN:  len_d    = wd_cnt;
        default:         ;
      endcase
    end

    // A retrigger wins over the decrement, so a reload at count 1 leaves no gap.
    for (int i = 0; i < int'(PIO_WIDTH); i++) begin
      pulse_active[i] = (pcnt_q[i] != '0);
      pcnt_d[i]       = pcnt_q[i];
      if (avs_write_i && avs_address_i == ADDR_PULSE && wd_pio[i] && len_q != '0)
        pcnt_d[i] = len_q;
      else if (pulse_active[i])
        pcnt_d[i] = pcnt_q[i] - CNT_WIDTH'(1);
    end
  end

  // Per-channel output selection: pulse over PWM over static level.
  always_comb begin
    pwm = (cnt_q < duty_q);
    for (int i = 0; i < int'(PIO_WIDTH); i++) begin
      if (pulse_active[i])   pio_d[i] = ~data_q[i];
      else if (pwm_en_q[i])  pio_d[i] = pwm;
      else                   pio_d[i] = data_q[i];
    end
  end

  // Read data is captured from pre-write state and held until the next read.
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read_i) begin
      case (avs_address_i)
        ADDR_DATA:       rdata_d = 32'(data_q);
        ADDR_PWM_EN:     rdata_d = 32'(pwm_en_q);
        ADDR_PWM_PERIOD: rdata_d = 32'(period_q);
        ADDR_PWM_DUTY:   rdata_d = 32'(duty_q);
        ADDR_PULSE:      rdata_d = 32'(pulse_active);
        ADDR_PULSE_LEN:  rdata_d = 32'(len_q);
        ADDR_STATUS:     rdata_d = 32'(pio_q);
        default:         rdata_d = '0;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q   <= RESET_VAL;
      pwm_en_q <= '0;
      period_q <= '0;
      duty_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      pio_q    <= RESET_VAL;
      rdata_q  <= '0;
    end else begin
      data_q   <= data_d;
      pwm_en_q <= pwm_en_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      pio_q    <= pio_d;
      rdata_q  <= rdata_d;
    end
  end

  assign pio_o          = pio_q;
  assign avs_readdata_o = rdata_q;

endmodule

// File: tb/tb_pio_ctrl_avmm.sv
// Self-checking bench for pio_ctrl_avmm: expected pin and read values are
// queued as stimulus is applied and compared as the DUT produces them.
module tb_pio_ctrl_avmm;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [3:0]    addr;
  logic          wr, rd;
  logic [31:0]   wdata, rdata;
  logic [W-1:0]  pio;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0]  pio_exp_q[$];
  logic [31:0]   rd_exp_q[$];

  pio_ctrl_avmm #(.PIO_WIDTH(W), .CNT_WIDTH(16), .RESET_VAL(8'hA5)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .avs_address_i  (addr),
    .avs_write_i    (wr),
    .avs_writedata_i(wdata),
    .avs_read_i     (rd),
    .avs_readdata_o (rdata),
    .pio_o          (pio)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); addr = a; wdata = d; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk); addr = a; rd = 1'b1;
    @(negedge clk); rd = 1'b0; d = rdata;
  endtask

  task automatic push_pio(input int n, input logic [W-1:0] v);
    for (int i = 0; i < n; i++) pio_exp_q.push_back(v);
  endtask

  // Consumes queued pin expectations one cycle at a time; optionally issues
  // a single write strobe sampled at the edge following cycle wk.
  task automatic drain_pio(input int n, input int wk, input logic [3:0] a,
                           input logic [31:0] d, input string name);
    logic [W-1:0] exp_v;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == wk + 1) wr = 1'b0;
      exp_v = pio_exp_q.pop_front();
      n_total++;
      if (pio !== exp_v) $display("FAIL %s cycle %0d: pio=%h expected %h", name, k, pio, exp_v);
      else n_pass++;
      if (k == wk) begin addr = a; wdata = d; wr = 1'b1; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] got, exp_v;
    rstn = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    #1 rstn = 1'b0;
    #1;
    n_total++;
    if (pio !== 8'hA5) $display("FAIL reset_async: pio=%h expected a5", pio); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (pio !== 8'hA5) $display("FAIL reset_hold: pio=%h expected a5", pio); else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
    n_total++;
    if (pio !== 8'hA5) $display("FAIL reset_release: pio=%h expected a5", pio); else n_pass++;
    for (int a = 0; a < 16; a++) begin
      rd_exp_q.push_back((a == 0 || a == 9) ? 32'hA5 : 32'h0);
      bus_read(4'(a), got);
      exp_v = rd_exp_q.pop_front();
      n_total++;
      if (got !== exp_v) $display("FAIL reset_readback addr %0d: got %h expected %h", a, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_data_ops();
    logic [3:0]  op_a [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    logic [7:0]  op_d [4] = '{8'h0F, 8'h30, 8'h01, 8'hFF};
    logic [7:0]  op_r [4] = '{8'h0F, 8'h3F, 8'h3E, 8'hC1};
    logic [7:0]  prev = 8'hA5;
    logic [31:0] got, exp_v;
    logic [3:0]  rd_a [5] = '{4'd0, 4'd9, 4'd1, 4'd2, 4'd3};
    for (int i = 0; i < 4; i++) begin
      bus_write(op_a[i], {24'hFFFFFF, op_d[i]});
      n_total++;
      if (pio !== prev) $display("FAIL data_latency op %0d: pio=%h expected %h", i, pio, prev);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (pio !== op_r[i]) $display("FAIL data_op %0d: pio=%h expected %h", i, pio, op_r[i]);
      else n_pass++;
      prev = op_r[i];
    end
    for (int i = 0; i < 5; i++) begin
      rd_exp_q.push_back(i < 2 ? 32'hC1 : 32'h0);
      bus_read(rd_a[i], got);
      exp_v = rd_exp_q.pop_front();
      n_total++;
      if (got !== exp_v) $display("FAIL data_read addr %0d: got %h expected %h", rd_a[i], got, exp_v);
      else n_pass++;
    end
    // Simultaneous read and write of DATA returns the old value.
    rd_exp_q.push_back(32'hC1);
    @(negedge clk); addr = 4'd0; wdata = 32'h55; wr = 1'b1; rd = 1'b1;
    @(negedge clk); wr = 1'b0; rd = 1'b0;
    exp_v = rd_exp_q.pop_front();
    n_total++;
    if (rdata !== exp_v) $display("FAIL rw_same_addr: got %h expected %h", rdata, exp_v); else n_pass++;
    bus_write(4'd12, 32'hFF);
    rd_exp_q.push_back(32'h0);
    bus_read(4'd12, got);
    exp_v = rd_exp_q.pop_front();
    n_total++;
    if (got !== exp_v) $display("FAIL unmapped_read: got %h expected %h", got, exp_v); else n_pass++;
    rd_exp_q.push_back(32'h55);
    bus_read(4'd0, got);
    exp_v = rd_exp_q.pop_front();
    n_total++;
    if (got !== exp_v) $display("FAIL data_after_rw: got %h expected %h", got, exp_v); else n_pass++;
    bus_write(4'd0, 32'h0);
  endtask

  task automatic test_pwm();
    logic [31:0] got, exp_v;
    logic [3:0]  rd_a [3] = '{4'd4, 4'd5, 4'd6};
    logic [31:0] rd_v [3] = '{32'h1, 32'd9, 32'd12};
    bus_write(4'd6, 32'd3);
    bus_write(4'd4, 32'h01);
    bus_write(4'd5, 32'd9);
    for (int k = 1; k <= 30; k++) pio_exp_q.push_back(((k - 1) % 10 < 3) ? 8'h01 : 8'h00);
    drain_pio(30, 0, 4'd0, 32'h0, "pwm_3_of_10");
    bus_write(4'd6, 32'd0);
    push_pio(20, 8'h00);
    drain_pio(20, 0, 4'd0, 32'h0, "pwm_duty0");
    bus_write(4'd6, 32'd12);
    push_pio(20, 8'h01);
    drain_pio(20, 0, 4'd0, 32'h0, "pwm_duty_gt_period");
    for (int i = 0; i < 3; i++) begin
      rd_exp_q.push_back(rd_v[i]);
      bus_read(rd_a[i], got);
      exp_v = rd_exp_q.pop_front();
      n_total++;
      if (got !== exp_v) $display("FAIL pwm_read addr %0d: got %h expected %h", rd_a[i], got, exp_v);
      else n_pass++;
    end
    bus_write(4'd4, 32'h0);
  endtask

  task automatic test_pulse();
    logic [31:0] got, exp_v;
    bus_write(4'd8, 32'd5);
    bus_write(4'd7, 32'h80);
    push_pio(5, 8'h80); push_pio(3, 8'h00);
    drain_pio(8, 0, 4'd0, 32'h0, "pulse_len5");
    bus_write(4'd7, 32'h80);
    rd_exp_q.push_back(32'h80);
    bus_read(4'd7, got);
    exp_v = rd_exp_q.pop_front();
    n_total++;
    if (got !== exp_v) $display("FAIL pulse_read_active: got %h expected %h", got, exp_v); else n_pass++;
    repeat (6) @(negedge clk);
    rd_exp_q.push_back(32'h0);
    bus_read(4'd7, got);
    exp_v = rd_exp_q.pop_front();
    n_total++;
    if (got !== exp_v) $display("FAIL pulse_read_idle: got %h expected %h", got, exp_v); else n_pass++;
    bus_write(4'd8, 32'd0);
    bus_write(4'd7, 32'hFF);
    push_pio(4, 8'h00);
    drain_pio(4, 0, 4'd0, 32'h0, "pulse_len0_noop");
    bus_write(4'd8, 32'd5);
  endtask

  task automatic test_back_to_back();
    bus_write(4'd7, 32'h80);
    push_pio(8, 8'h80); push_pio(4, 8'h00);
    drain_pio(12, 2, 4'd7, 32'h80, "retrigger_mid");
    bus_write(4'd7, 32'h80);
    push_pio(10, 8'h80); push_pio(2, 8'h00);
    drain_pio(12, 4, 4'd7, 32'h80, "retrigger_at_1");
    bus_write(4'd7, 32'h80);
    push_pio(3, 8'h80); push_pio(2, 8'h00); push_pio(3, 8'h80);
    drain_pio(8, 2, 4'd0, 32'h80, "pulse_polarity_flip");
    bus_write(4'd0, 32'h0);
    // Pulse overrides a PWM channel held low, then PWM takes over again.
    bus_write(4'd6, 32'd0);
    bus_write(4'd4, 32'h01);
    bus_write(4'd7, 32'h01);
    push_pio(5, 8'h01); push_pio(3, 8'h00);
    drain_pio(8, 0, 4'd0, 32'h0, "pulse_over_pwm");
    bus_write(4'd6, 32'd12);
    push_pio(5, 8'h01);
    drain_pio(5, 0, 4'd0, 32'h0, "pwm_resume");
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp_v;
    logic [3:0]  rd_a [4] = '{4'd7, 4'd4, 4'd5, 4'd0};
    logic [31:0] rd_v [4] = '{32'h0, 32'h0, 32'h0, 32'hA5};
    bus_write(4'd5, 32'd3);
    bus_write(4'd6, 32'd2);
    bus_write(4'd8, 32'd20);
    bus_write(4'd7, 32'h80);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_total++;
    if (pio !== 8'hA5) $display("FAIL reset_mid_async: pio=%h expected a5", pio); else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    push_pio(20, 8'hA5);
    drain_pio(20, 0, 4'd0, 32'h0, "reset_mid_quiet");
    for (int i = 0; i < 4; i++) begin
      rd_exp_q.push_back(rd_v[i]);
      bus_read(rd_a[i], got);
      exp_v = rd_exp_q.pop_front();
      n_total++;
      if (got !== exp_v) $display("FAIL reset_mid_read addr %0d: got %h expected %h", rd_a[i], got, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_data_ops();
    test_pwm();
    test_pulse();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
